axis_rr_arbiter: RTL and testbench
==================================

Name: axis_rr_arbiter

Overview:
- Shares one AXIS sink (for example a checker or a downstream core) between NUM_INPUTS AXIS source streams.
- Uses round-robin scheduling with packet locking: once an input is granted, it keeps the output until its packet ends.
- Placed between several generators or readers and a single consumer in test benches and datapaths.
- Reports the granted input index alongside each beat.

Parameters:
- DATA_WIDTH, 10, bit width of each data lane.
- NUM_INPUTS, 4, number of requesting streams; legal range is 2 to 16.
- ID_WIDTH, $clog2(NUM_INPUTS), width of output_id.
- PACKET_MODE, 1: grant is held until a beat with last=1 transfers. 0: grant is released after every transferred beat.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- input_valid  in  NUM_INPUTS  per-input valid.
- input_data  in  NUM_INPUTS*DATA_WIDTH  per-input data; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- input_last  in  NUM_INPUTS  per-input end-of-packet flag.
- input_ready  out  NUM_INPUTS  per-input ready.
- output_valid  out  1  merged valid.
- output_data  out  DATA_WIDTH  merged data.
- output_last  out  1  merged last.
- output_id  out  ID_WIDTH  index of the currently granted input.
- output_ready  in  1  downstream ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, grant=0, ptr=0.
  - output_valid=0, input_ready=all 0, output_id=0.
  - Reset in the middle of a packet drops the packet. No beat is replayed.
- State IDLE:
  - output_valid=0 and input_ready=0. output_data and output_last are don't-care.
  - If any input_valid bit is 1, choose the first index i with input_valid[i]=1, scanning ptr, ptr+1, …, NUM_INPUTS-1, 0, … (wrap-around).
  - Register grant<=i, ptr<=(i+1) mod NUM_INPUTS, state<=LOCKED.
  - If no input_valid bit is 1, stay in IDLE with ptr unchanged.
- State LOCKED (combinational pass-through of the granted input):
  - output_valid=input_valid[grant], output_data=input_data[grant], output_last=input_last[grant].
  - input_ready[grant]=output_ready; all other input_ready bits are 0.
  - output_id=grant, held for the whole lock.
- Release:
  - A transfer is output_valid & output_ready.
  - PACKET_MODE=1: a transfer with output_last=1 sets state<=IDLE.
  - PACKET_MODE=0: every transfer sets state<=IDLE.
  - Transfers with last=0 in PACKET_MODE=1 stay LOCKED.
  - If input_valid[grant] drops mid-packet, the block stays LOCKED indefinitely, with no timeout.
- Latency and throughput:
  - One IDLE arbitration cycle precedes each grant, so the first beat is available one cycle after the request is seen.
  - Beats within a packet flow at 1 per cycle.
  - There is a 1-cycle bubble between packets.
- Fairness:
  - An input that keeps input_valid asserted is granted within NUM_INPUTS grants.
  - Requests arriving in the same cycle as a release are seen at the next IDLE cycle.
- output_id changes only on the IDLE→LOCKED transition.
- The block never reorders or duplicates beats: every beat transfers exactly once, on exactly one input/output pair.

Test Plan:
1. Reset: hold rst=0 with all input_valid=1 → output_valid=0, input_ready=0000, output_id=0. After rst=1 → first grant goes to input 0 (ptr=0).
2. Contention, PACKET_MODE=1, NUM_INPUTS=4, DATA_WIDTH=8, output_ready=1: each input sends a 3-beat packet with data {i0,i1,i2} (input 0 sends 0x00,0x01,0x02; input 3 sends 0x30,0x31,0x32) → output order is input 0,1,2,3. Each packet is contiguous with output_id constant, followed by one bubble cycle. Total 16 cycles from first grant to last beat.
3. Round-robin wrap: only inputs 1 and 3 request continuously with 1-beat packets → grants alternate 1,3,1,3. After input 3, ptr wraps to 0 and skips idle inputs 0 and 2.
4. Backpressure: output_ready toggles 1,0,1,0 during a locked 4-beat packet on input 2 → data 0x20..0x23 delivered in order with no loss or duplication. input_ready[2] mirrors output_ready; other input_ready bits stay 0. A competing input 0 waits until after the beat with last=1.
5. PACKET_MODE=0: inputs 0 and 1 each hold 2 beats with last=0 → output interleaves 0,1,0,1 with a bubble between beats. The last flag is ignored for release.
6. Asynchronous reset mid-packet: rst pulses low between clock edges after beat 2 of 4 on input 1 → output_valid and input_ready fall immediately. After release, a fresh arbitration starts from ptr=0, and input 0 wins if requesting.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXIS arbiter: merges NUM_INPUTS streams into one sink,
// locking the grant until packet end (or per beat when PACKET_MODE=0).
module axis_rr_arbiter #(
  parameter int DATA_WIDTH  = 10,
  parameter int NUM_INPUTS  = 4,
  parameter int ID_WIDTH    = $clog2(NUM_INPUTS),
  parameter int PACKET_MODE = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS-1:0]            input_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] input_data,
  input  logic [NUM_INPUTS-1:0]            input_last,
  output logic [NUM_INPUTS-1:0]            input_ready,
  output logic                             output_valid,
  output logic [DATA_WIDTH-1:0]            output_data,
  output logic                             output_last,
  output logic [ID_WIDTH-1:0]              output_id,
  input  logic                             output_ready
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  localparam logic PKT = (PACKET_MODE != 0);

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;

  logic                found;
  logic [ID_WIDTH-1:0] cand;
  logic [ID_WIDTH-1:0] pick;
  logic [ID_WIDTH-1:0] pick_nxt;

  logic                sel_valid;
  logic                sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                xfer;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    found    = 1'b0;
    cand     = '0;
    pick     = '0;
    pick_nxt = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand = ID_WIDTH'((int'(ptr_q) + k) % NUM_INPUTS);
      if (!found && input_valid[cand]) begin
        found    = 1'b1;
        pick     = cand;
        pick_nxt = ID_WIDTH'((int'(ptr_q) + k + 1) % NUM_INPUTS);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_valid = input_valid[i];
        sel_last  = input_last[i];
        sel_data  = input_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    output_valid = 1'b0;
    output_last  = sel_last;
    output_data  = sel_data;
    output_id    = grant_q;
    input_ready  = '0;
    if (state_q == LOCKED) begin
      output_valid = sel_valid;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (grant_q == ID_WIDTH'(i)) begin
          input_ready[i] = output_ready;
        end
      end
    end
  end

  assign xfer = output_valid & output_ready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          ptr_d   = pick_nxt;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer && (output_last || !PKT)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: directed scenarios and random traffic
// against a queue-based model, one packet-mode and one beat-mode instance.
module tb_axis_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    iv [2];
  logic [N-1:0]    il [2];
  logic [N-1:0]    ir [2];
  logic [N*DW-1:0] id [2];
  logic            ov [2];
  logic            ol [2];
  logic            orr[2];
  logic [DW-1:0]   od [2];
  logic [IW-1:0]   oi [2];

  axis_rr_arbiter #(
    .DATA_WIDTH(DW), .NUM_INPUTS(N), .ID_WIDTH(IW), .PACKET_MODE(1)
  ) u_pm1 (
    .clk(clk), .rst(rst),
    .input_valid(iv[0]), .input_data(id[0]), .input_last(il[0]),
    .input_ready(ir[0]),
    .output_valid(ov[0]), .output_data(od[0]), .output_last(ol[0]),
    .output_id(oi[0]), .output_ready(orr[0])
  );

  axis_rr_arbiter #(
    .DATA_WIDTH(DW), .NUM_INPUTS(N), .ID_WIDTH(IW), .PACKET_MODE(0)
  ) u_pm0 (
    .clk(clk), .rst(rst),
    .input_valid(iv[1]), .input_data(id[1]), .input_last(il[1]),
    .input_ready(ir[1]),
    .output_valid(ov[1]), .output_data(od[1]), .output_last(ol[1]),
    .output_id(oi[1]), .output_ready(orr[1])
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] q [N][$];
  int         xid[$];
  logic [7:0] xd [$];

  int owner[2];
  int mptr [2];
  int mid  [2];
  bit pm   [2] = '{1'b1, 1'b0};
  int act;
  bit gap_en;
  int rmode;
  bit tg;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic void mreset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1;
      mptr[k]  = 0;
      mid[k]   = 0;
    end
  endfunction

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) if (q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic clear_log();
    xid.delete();
    xd.delete();
  endtask

  task automatic step();
    logic [N-1:0] vv;
    logic [N-1:0] er;
    logic         orv, ev, el, xf;
    logic [7:0]   ed;
    int           o;
    for (int j = 0; j < 2; j++) begin
      iv[j] = '0; il[j] = '0; id[j] = '0; orr[j] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      vv[i] = (q[i].size() > 0) &&
              !(gap_en && ($urandom_range(0, 3) == 0));
      if (q[i].size() > 0) begin
        id[act][i*DW +: DW] = q[i][0][7:0];
        il[act][i]          = q[i][0][8];
      end
    end
    iv[act] = vv;
    case (rmode)
      0:       orv = 1'b1;
      1:       begin orv = tg; tg = ~tg; end
      default: orv = 1'($urandom_range(0, 1));
    endcase
    orr[act] = orv;
    #1;
    o = owner[act]; ev = 1'b0; el = 1'b0; ed = '0; er = '0;
    if (o >= 0) begin
      ev    = vv[o];
      er[o] = orv;
      if (ev) begin
        ed = q[o][0][7:0];
        el = q[o][0][8];
      end
    end
    chk("output_valid", 32'(ov[act]), 32'(ev));
    chk("input_ready", 32'(ir[act]), 32'(er));
    chk("output_id", 32'(oi[act]), 32'(mid[act]));
    if (ev) begin
      chk("output_data", 32'(od[act]), 32'(ed));
      chk("output_last", 32'(ol[act]), 32'(el));
    end
    xf = ev && orv;
    @(posedge clk);
    if (o < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (mptr[act] + k) % N;
        if (vv[c] && owner[act] < 0) begin
          owner[act] = c;
          mid[act]   = c;
          mptr[act]  = (c + 1) % N;
        end
      end
    end else if (xf) begin
      xid.push_back(o);
      xd.push_back(ed);
      void'(q[o].pop_front());
      if (el || !pm[act]) owner[act] = -1;
    end
    @(negedge clk);
  endtask

  task automatic drain(input int maxc, output int n);
    bit done;
    n = 0;
    while (!(all_empty() && owner[act] < 0) && n < maxc) begin
      step();
      n++;
    end
    done = all_empty() && (owner[act] < 0);
    chk("drain_done", 32'(done), 32'd1);
  endtask

  task automatic push_pkt(input int i, input int len, input logic [7:0] base,
                          input bit last_end);
    for (int b = 0; b < len; b++)
      q[i].push_back({(last_end && b == len - 1), 8'(base + 8'(b))});
  endtask

  int n;
  int total;

  initial begin
    mreset();
    act = 0; gap_en = 0; rmode = 0; tg = 1'b1;
    for (int j = 0; j < 2; j++) begin
      iv[j] = '1; il[j] = '1; id[j] = '0; orr[j] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      chk("rst_output_valid", 32'(ov[j]), 32'd0);
      chk("rst_input_ready", 32'(ir[j]), 32'd0);
      chk("rst_output_id", 32'(oi[j]), 32'd0);
    end
    for (int j = 0; j < 2; j++) iv[j] = '0;
    rst = 1'b1;
    @(negedge clk);

    // Contention: four 3-beat packets, order 0..3, 16 cycles.
    clear_log();
    for (int i = 0; i < N; i++) push_pkt(i, 3, 8'(i * 16), 1'b1);
    drain(200, n);
    chk("contention_cycles", 32'(n), 32'd16);
    chk("contention_beats", 32'(xid.size()), 32'd12);
    for (int k = 0; k < 12 && k < xid.size(); k++) begin
      chk("contention_id", 32'(xid[k]), 32'(k / 3));
      chk("contention_data", 32'(xd[k]), 32'((k / 3) * 16 + k % 3));
    end

    // Wrap: only inputs 1 and 3, single-beat packets.
    clear_log();
    for (int r = 0; r < 2; r++) begin
      push_pkt(1, 1, 8'h40 + 8'(r), 1'b1);
      push_pkt(3, 1, 8'h60 + 8'(r), 1'b1);
    end
    drain(200, n);
    chk("wrap_beats", 32'(xid.size()), 32'd4);
    for (int k = 0; k < 4 && k < xid.size(); k++)
      chk("wrap_id", 32'(xid[k]), (k % 2 == 0) ? 32'd1 : 32'd3);

    // Backpressure on input 2 with input 0 competing.
    clear_log();
    rmode = 1; tg = 1'b1;
    push_pkt(2, 4, 8'h20, 1'b1);
    step();
    push_pkt(0, 1, 8'h05, 1'b1);
    drain(200, n);
    chk("bp_beats", 32'(xid.size()), 32'd5);
    for (int k = 0; k < 4 && k < xid.size(); k++) begin
      chk("bp_id", 32'(xid[k]), 32'd2);
      chk("bp_data", 32'(xd[k]), 32'h20 + 32'(k));
    end
    if (xid.size() == 5) chk("bp_after_id", 32'(xid[4]), 32'd0);

    // Beat mode: interleave 0,1,0,1 with last=0 everywhere.
    clear_log();
    act = 1; rmode = 0;
    push_pkt(0, 2, 8'h00, 1'b0);
    push_pkt(1, 2, 8'h10, 1'b0);
    drain(200, n);
    chk("pm0_cycles", 32'(n), 32'd8);
    chk("pm0_beats", 32'(xid.size()), 32'd4);
    for (int k = 0; k < 4 && k < xid.size(); k++)
      chk("pm0_id", 32'(xid[k]), 32'(k % 2));
    if (xd.size() == 4) chk("pm0_data2", 32'(xd[2]), 32'h01);

    // Async reset mid-packet on input 1.
    act = 0;
    clear_log();
    push_pkt(1, 4, 8'h10, 1'b1);
    push_pkt(0, 1, 8'h07, 1'b1);
    repeat (3) step();
    chk("mid_beats", 32'(xid.size()), 32'd2);
    rst = 1'b0;
    #1;
    chk("arst_output_valid", 32'(ov[0]), 32'd0);
    chk("arst_input_ready", 32'(ir[0]), 32'd0);
    chk("arst_output_id", 32'(oi[0]), 32'd0);
    mreset();
    q[1].delete();
    clear_log();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    push_pkt(1, 2, 8'h50, 1'b1);
    drain(200, n);
    chk("post_rst_beats", 32'(xid.size()), 32'd3);
    if (xid.size() > 0) begin
      chk("post_rst_first_id", 32'(xid[0]), 32'd0);
      chk("post_rst_first_data", 32'(xd[0]), 32'h07);
    end

    // Random traffic on both instances.
    gap_en = 1; rmode = 2;
    for (int r = 0; r < 8; r++) begin
      act = r % 2;
      clear_log();
      total = 0;
      for (int i = 0; i < N; i++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          int len;
          len = $urandom_range(1, 4);
          push_pkt(i, len, 8'($urandom_range(0, 255)), 1'b1);
          total += len;
        end
      end
      drain(3000, n);
      chk("rand_beats", 32'(xid.size()), 32'(total));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
